display_scan_mux: RTL and testbench



---
 rtl/display_scan_mux.sv | 136 +++++++++++++
 tb/tb_display_scan_mux.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - 3-digit scan multiplexer feeding a 7-segment decoder
// New values are double-buffered and take effect only at frame boundaries.
module display_scan_mux #(
  parameter int TICK_DIV   = 50000,
  parameter int NUM_DIGITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] value_in,
  input  logic [2:0]  dp_mask_in,
  input  logic        blank_lz_in,
  input  logic        load_in,
  output logic [1:0]  en_out,
  output logic [3:0]  display_out,
  output logic        dp_out,
  output logic        frame_done_out,
  output logic        pending_out
);

  localparam int         CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   act_val_q, act_val_d;
  logic [2:0]    act_dp_q, act_dp_d;
  logic          act_blz_q, act_blz_d;
  logic [11:0]   pend_val_q, pend_val_d;
  logic [2:0]    pend_dp_q, pend_dp_d;
  logic          pend_blz_q, pend_blz_d;
  logic          pend_valid_q, pend_valid_d;
  logic [1:0]    en_q, en_d;
  logic [3:0]    disp_q, disp_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          tick, boundary;
  logic [3:0]    nib;
  logic          blank;

  always_comb begin
    tick     = (cnt_q == CW'(TICK_DIV - 1));
    boundary = tick && (idx_q == LAST_IDX);
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;

    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blz_d    = act_blz_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blz_d   = pend_blz_q;
    pend_valid_d = pend_valid_q;
    if (boundary) begin
      // A load landing exactly on the boundary bypasses the pending buffer.
      if (load_in) begin
        act_val_d = value_in;
        act_dp_d  = dp_mask_in;
        act_blz_d = blank_lz_in;
      end else if (pend_valid_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
        act_blz_d = pend_blz_q;
      end
      pend_valid_d = 1'b0;
    end else if (load_in) begin
      pend_val_d   = value_in;
      pend_dp_d    = dp_mask_in;
      pend_blz_d   = blank_lz_in;
      pend_valid_d = 1'b1;
    end

    case (idx_q)
      2'd0:    nib = act_val_q[3:0];
      2'd1:    nib = act_val_q[7:4];
      2'd2:    nib = act_val_q[11:8];
      default: nib = 4'd0;
    endcase
    case (idx_q)
      2'd1:    blank = act_blz_q && (act_val_q[11:4] == 8'd0);
      2'd2:    blank = act_blz_q && (act_val_q[11:8] == 4'd0);
      default: blank = 1'b0;
    endcase

    if (blank) begin
      en_d   = 2'd3;
      disp_d = 4'd0;
      dp_d   = 1'b0;
    end else begin
      en_d   = idx_q;
      disp_d = nib;
      dp_d   = act_dp_q[idx_q];
    end
    frame_done_d = boundary;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      act_val_q    <= 12'd0;
      act_dp_q     <= 3'd0;
      act_blz_q    <= 1'b0;
      pend_val_q   <= 12'd0;
      pend_dp_q    <= 3'd0;
      pend_blz_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      en_q         <= 2'd3;
      disp_q       <= 4'd0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blz_q    <= act_blz_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blz_q   <= pend_blz_d;
      pend_valid_q <= pend_valid_d;
      en_q         <= en_d;
      disp_q       <= disp_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign en_out         = en_q;
  assign display_out    = disp_q;
  assign dp_out         = dp_q;
  assign frame_done_out = frame_done_q;
  assign pending_out    = pend_valid_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - self-checking bench for display_scan_mux
// Frame-level model compared every cycle, plus literal expectations per scenario.
module tb_display_scan_mux;

  localparam int TD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] value_in = 12'd0;
  logic [2:0]  dp_mask_in = 3'd0;
  logic        blank_lz_in = 1'b0;
  logic        load_in = 1'b0;
  logic [1:0]  en_out;
  logic [3:0]  display_out;
  logic        dp_out;
  logic        frame_done_out;
  logic        pending_out;

  display_scan_mux #(.TICK_DIV(TD), .NUM_DIGITS(3)) dut (
    .clock(clock), .reset(reset), .value_in(value_in), .dp_mask_in(dp_mask_in),
    .blank_lz_in(blank_lz_in), .load_in(load_in), .en_out(en_out),
    .display_out(display_out), .dp_out(dp_out), .frame_done_out(frame_done_out),
    .pending_out(pending_out)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;
  int kk     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: time since reset, frame slot by division, value swap at frame end
  int          m_t;
  logic [11:0] m_val, m_pval;
  logic [2:0]  m_dp, m_pdp;
  logic        m_blz, m_pblz, m_pv;
  logic [1:0]  exp_en;
  logic [3:0]  exp_disp;
  logic        exp_dp, exp_fd, exp_pend;

  function automatic logic [6:0] slot_out(input int slot, input logic [11:0] v,
                                          input logic [2:0] dpm, input logic blz);
    logic [3:0] n;
    bit lead_zero;
    n = 4'((v >> (4 * slot)) & 12'hF);
    lead_zero = 1'b1;
    for (int j = slot; j < 3; j++)
      if (((v >> (4 * j)) & 12'hF) != 12'd0) lead_zero = 1'b0;
    if (blz && slot > 0 && lead_zero) return {2'd3, 4'd0, 1'b0};
    return {2'(slot), n, dpm[slot]};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_t <= 0; m_val <= 0; m_dp <= 0; m_blz <= 0; m_pv <= 0;
      exp_en <= 2'd3; exp_disp <= 0; exp_dp <= 0; exp_fd <= 0; exp_pend <= 0;
    end else begin
      int  slot;
      bit  bnd;
      slot = (m_t / TD) % 3;
      bnd  = ((m_t % TD) == TD - 1) && slot == 2;
      {exp_en, exp_disp, exp_dp} <= slot_out(slot, m_val, m_dp, m_blz);
      exp_fd <= bnd;
      if (bnd) begin
        if (load_in) begin
          m_val <= value_in; m_dp <= dp_mask_in; m_blz <= blank_lz_in;
        end else if (m_pv) begin
          m_val <= m_pval; m_dp <= m_pdp; m_blz <= m_pblz;
        end
        m_pv <= 0; exp_pend <= 0;
      end else if (load_in) begin
        m_pval <= value_in; m_pdp <= dp_mask_in; m_pblz <= blank_lz_in;
        m_pv <= 1; exp_pend <= 1;
      end else begin
        exp_pend <= m_pv;
      end
      m_t <= m_t + 1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model en", 32'(en_out), 32'(exp_en));
      check("model display", 32'(display_out), 32'(exp_disp));
      check("model dp", 32'(dp_out), 32'(exp_dp));
      check("model frame_done", 32'(frame_done_out), 32'(exp_fd));
      check("model pending", 32'(pending_out), 32'(exp_pend));
    end
  end

  task automatic goto_k(input int target);
    while (kk < target) begin
      @(negedge clock);
      kk++;
    end
  endtask

  task automatic load_at(input int k, input logic [11:0] v, input logic [2:0] m, input logic b);
    goto_k(k);
    value_in = v; dp_mask_in = m; blank_lz_in = b; load_in = 1'b1;
    goto_k(k + 1);
    load_in = 1'b0;
  endtask

  task automatic lit(input int k, input string name, input logic [1:0] en, input logic [3:0] d,
                     input logic dp);
    goto_k(k);
    check({name, " en"}, 32'(en_out), 32'(en));
    check({name, " display"}, 32'(display_out), 32'(d));
    check({name, " dp"}, 32'(dp_out), 32'(dp));
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("reset en", 32'(en_out), 32'd3);
    check("reset display", 32'(display_out), 32'd0);
    check("reset dp", 32'(dp_out), 32'd0);
    check("reset frame_done", 32'(frame_done_out), 32'd0);
    check("reset pending", 32'(pending_out), 32'd0);
    reset = 1'b0;
    kk = 0;

    lit(1, "first slot", 2'd0, 4'd0, 1'b0);
    lit(5, "scan idx1", 2'd1, 4'd0, 1'b0);
    lit(9, "scan idx2", 2'd2, 4'd0, 1'b0);
    goto_k(11); check("no early frame_done", 32'(frame_done_out), 32'd0);
    goto_k(12); check("frame_done pulse", 32'(frame_done_out), 32'd1);

    load_at(12, 12'h5A3, 3'b010, 1'b0);
    check("pending after load", 32'(pending_out), 32'd1);
    lit(20, "deferred old frame", 2'd1, 4'd0, 1'b0);
    goto_k(23); check("pending held", 32'(pending_out), 32'd1);
    load_at(24, 12'h007, 3'b000, 1'b1);
    lit(25, "5A3 slot0", 2'd0, 4'h3, 1'b0);
    lit(29, "5A3 slot1", 2'd1, 4'hA, 1'b1);
    lit(33, "5A3 slot2", 2'd2, 4'h5, 1'b0);

    load_at(36, 12'h000, 3'b000, 1'b1);
    lit(37, "007 slot0", 2'd0, 4'h7, 1'b0);
    lit(41, "007 slot1", 2'd3, 4'h0, 1'b0);
    lit(45, "007 slot2", 2'd3, 4'h0, 1'b0);
    load_at(48, 12'h070, 3'b000, 1'b1);
    lit(49, "000 slot0", 2'd0, 4'h0, 1'b0);
    lit(53, "000 slot1", 2'd3, 4'h0, 1'b0);
    load_at(60, 12'h007, 3'b100, 1'b1);
    lit(61, "070 slot0", 2'd0, 4'h0, 1'b0);
    lit(65, "070 slot1", 2'd1, 4'h7, 1'b0);
    lit(69, "070 slot2", 2'd3, 4'h0, 1'b0);
    lit(81, "blank dp suppressed", 2'd3, 4'h0, 1'b0);

    load_at(83, 12'h123, 3'b000, 1'b0);
    check("bypass no pending", 32'(pending_out), 32'd0);
    lit(85, "123 slot0", 2'd0, 4'h3, 1'b0);
    lit(89, "123 slot1", 2'd1, 4'h2, 1'b0);
    lit(93, "123 slot2", 2'd2, 4'h1, 1'b0);

    load_at(96, 12'h111, 3'b000, 1'b0);
    load_at(100, 12'h222, 3'b000, 1'b0);
    lit(109, "last wins slot0", 2'd0, 4'h2, 1'b0);
    lit(113, "last wins slot1", 2'd1, 4'h2, 1'b0);
    lit(117, "last wins slot2", 2'd2, 4'h2, 1'b0);

    load_at(120, 12'h999, 3'b111, 1'b0);
    goto_k(125);
    reset = 1'b1;
    goto_k(126);
    reset = 1'b0;
    check("midreset en", 32'(en_out), 32'd3);
    check("midreset display", 32'(display_out), 32'd0);
    check("midreset pending", 32'(pending_out), 32'd0);
    kk = 0;
    lit(1, "restart slot0", 2'd0, 4'd0, 1'b0);
    lit(5, "restart slot1", 2'd1, 4'd0, 1'b0);
    lit(17, "discarded pending", 2'd1, 4'd0, 1'b0);
    goto_k(18); check("no pending after reset", 32'(pending_out), 32'd0);
    lit(29, "still zero", 2'd1, 4'd0, 1'b0);
    goto_k(30);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
